// File: rtl/stroke_rasterizer_if.sv
// Pixel write port from the stroke rasterizer to the frame buffer.
// Valid/ready handshake carrying one clipped pixel per transfer.
interface stroke_rasterizer_if #(
  parameter int COLOR_W = 4
);
  logic               wr_valid_out;
  logic               wr_ready_in;
  logic [9:0]         wr_x_out;
  logic [8:0]         wr_y_out;
  logic [COLOR_W-1:0] wr_color_out;

  modport master (
    output wr_valid_out, wr_x_out, wr_y_out, wr_color_out,
    input  wr_ready_in
  );

  modport slave (
    input  wr_valid_out, wr_x_out, wr_y_out, wr_color_out,
    output wr_ready_in
  );
endinterface

// File: rtl/stroke_rasterizer.sv
// Per-frame stroke rasterizer: Bresenham line from the previous cursor sample
// to the current one, stamping a clipped square brush at every line point.
module stroke_rasterizer #(
  parameter int H_MAX   = 320,
  parameter int V_MAX   = 180,
  parameter int COLOR_W = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [9:0]         x_in,
  input  logic [8:0]         y_in,
  input  logic [COLOR_W-1:0] color_in,
  input  logic [2:0]         sw_in,
  input  logic               pen_down_in,
  input  logic               nf_in,
  stroke_rasterizer_if.master wr,
  output logic               busy_out
);
  typedef enum logic [1:0] {IDLE, SETUP, STAMP, STEP} state_t;
  typedef logic signed [11:0] coord_t;

  state_t state, state_nxt;

  logic               nf_q, pen_q;
  logic [9:0]         x_s;
  logic [8:0]         y_s;
  logic [COLOR_W-1:0] color_s;
  logic [2:0]         sw_s;

  coord_t             x0, y0, x1, y1, dx, dy, sx, sy, err;
  logic [2:0]         sw_q, i_q, j_q;
  logic [COLOR_W-1:0] color_q;
  logic [9:0]         prev_x;
  logic [8:0]         prev_y;
  logic               prev_pen;

  coord_t r, cx, cy, e2, ddx, ddy, adx, ady;
  logic   in_range, take, last_pix, at_end, step_x, step_y;

  always_comb begin
    r        = coord_t'({10'd0, sw_q[2:1]});
    cx       = x0 - r + coord_t'({9'd0, i_q});
    cy       = y0 - r + coord_t'({9'd0, j_q});
    in_range = !cx[11] && !cy[11] && (cx < coord_t'(H_MAX)) && (cy < coord_t'(V_MAX));
    // Out-of-range candidates are skipped without waiting for the sink.
    take     = (state == STAMP) && (!in_range || wr.wr_ready_in);
    last_pix = (i_q == sw_q) && (j_q == sw_q);
    at_end   = (x0 == x1) && (y0 == y1);
    ddx      = x1 - x0;
    ddy      = y1 - y0;
    adx      = ddx[11] ? -ddx : ddx;
    ady      = ddy[11] ? -ddy : ddy;
    e2       = err <<< 1;
    step_x   = (e2 >= dy);
    step_y   = (e2 <= dx);
  end

  // The frame pulse and cursor are captured once; the FSM acts on the copy.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      nf_q    <= 1'b0;
      pen_q   <= 1'b0;
      x_s     <= '0;
      y_s     <= '0;
      color_s <= '0;
      sw_s    <= '0;
    end else begin
      nf_q <= nf_in && (state == IDLE);
      if (nf_in && (state == IDLE)) begin
        pen_q   <= pen_down_in;
        x_s     <= x_in;
        y_s     <= y_in;
        color_s <= color_in;
        sw_s    <= sw_in;
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  // NOTE: defaulting state_nxt first keeps this comb block latch-free.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (nf_q && pen_q) state_nxt = SETUP;
      SETUP: state_nxt = STAMP;
      STAMP: if (take && last_pix) state_nxt = at_end ? IDLE : STEP;
      STEP:  state_nxt = STAMP;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr.wr_valid_out = 1'b0;
    wr.wr_x_out     = '0;
    wr.wr_y_out     = '0;
    wr.wr_color_out = '0;
    busy_out        = (state != IDLE);
    if (state == STAMP && in_range) begin
      wr.wr_valid_out = 1'b1;
      wr.wr_x_out     = cx[9:0];
      wr.wr_y_out     = cy[8:0];
      wr.wr_color_out = color_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      x0 <= '0; y0 <= '0; x1 <= '0; y1 <= '0;
      dx <= '0; dy <= '0; sx <= '0; sy <= '0; err <= '0;
      sw_q <= '0; i_q <= '0; j_q <= '0; color_q <= '0;
      prev_x <= '0; prev_y <= '0; prev_pen <= 1'b0;
    end else begin
      case (state)
        IDLE: if (nf_q) begin
          if (pen_q) begin
            x1      <= coord_t'({2'b0, x_s});
            y1      <= coord_t'({3'b0, y_s});
            x0      <= coord_t'({2'b0, prev_pen ? prev_x : x_s});
            y0      <= coord_t'({3'b0, prev_pen ? prev_y : y_s});
            color_q <= color_s;
            sw_q    <= sw_s;
          end else begin
            prev_pen <= 1'b0;
          end
        end
        SETUP: begin
          dx  <= adx;
          dy  <= -ady;
          sx  <= (x0 < x1) ? coord_t'(1) : coord_t'(-1);
          sy  <= (y0 < y1) ? coord_t'(1) : coord_t'(-1);
          err <= adx - ady;
          i_q <= '0;
          j_q <= '0;
        end
        STAMP: if (take) begin
          if (i_q == sw_q) begin
            i_q <= '0;
            j_q <= j_q + 3'd1;
          end else begin
            i_q <= i_q + 3'd1;
          end
          if (last_pix && at_end) begin
            prev_x   <= x1[9:0];
            prev_y   <= y1[8:0];
            prev_pen <= 1'b1;
          end
        end
        STEP: begin
          // Both axis decisions use the error term from before this step.
          if (step_x) x0 <= x0 + sx;
          if (step_y) y0 <= y0 + sy;
          err <= err + (step_x ? dy : coord_t'(0)) + (step_y ? dx : coord_t'(0));
          i_q <= '0;
          j_q <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_stroke_rasterizer.sv
// Self-checking bench for stroke_rasterizer: directed vector table, corner
// sequences and randomized strokes against a plain Bresenham/brush model.
module tb_stroke_rasterizer;
  localparam int H_MAX   = 320;
  localparam int V_MAX   = 180;
  localparam int COLOR_W = 4;

  logic               clk_in = 1'b0;
  logic               rst_in = 1'b0;
  logic [9:0]         x_in;
  logic [8:0]         y_in;
  logic [COLOR_W-1:0] color_in;
  logic [2:0]         sw_in;
  logic               pen_down_in;
  logic               nf_in;
  logic               busy_out;

  stroke_rasterizer_if #(.COLOR_W(COLOR_W)) bus ();

  stroke_rasterizer #(.H_MAX(H_MAX), .V_MAX(V_MAX), .COLOR_W(COLOR_W)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .x_in        (x_in),
    .y_in        (y_in),
    .color_in    (color_in),
    .sw_in       (sw_in),
    .pen_down_in (pen_down_in),
    .nf_in       (nf_in),
    .wr          (bus.master),
    .busy_out    (busy_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [9:0]         x;
    logic [8:0]         y;
    logic [COLOR_W-1:0] c;
  } pix_t;

  typedef struct {
    int x, y, c, sw;
    bit pen;
    int n, fx, fy, lx, ly;
  } vec_t;

  pix_t act_q[$];
  pix_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   ready_pct = 100;
  int   m_px, m_py;
  bit   m_pen;
  vec_t tbl[13];

  always @(negedge clk_in)
    if (rst_in && bus.wr_valid_out && bus.wr_ready_in)
      act_q.push_back({bus.wr_x_out, bus.wr_y_out, bus.wr_color_out});

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: textbook Bresenham loop, square brush of side sw+1 centred by sw/2.
  task automatic model_stroke(int x, int y, int c, int sw, bit pen);
    int x0, y0, dx, dy, sx, sy, err, e2, r;
    exp_q.delete();
    if (!pen) begin
      m_pen = 1'b0;
      return;
    end
    x0  = m_pen ? m_px : x;
    y0  = m_pen ? m_py : y;
    dx  = (x > x0) ? x - x0 : x0 - x;
    dy  = -((y > y0) ? y - y0 : y0 - y);
    sx  = (x0 < x) ? 1 : -1;
    sy  = (y0 < y) ? 1 : -1;
    err = dx + dy;
    r   = sw / 2;
    forever begin
      for (int j = 0; j <= sw; j++) begin
        for (int i = 0; i <= sw; i++) begin
          int px, py;
          px = x0 - r + i;
          py = y0 - r + j;
          if (px >= 0 && px < H_MAX && py >= 0 && py < V_MAX)
            exp_q.push_back({10'(px), 9'(py), COLOR_W'(c)});
        end
      end
      if (x0 == x && y0 == y) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x0 += sx; end
      if (e2 <= dx) begin err += dx; y0 += sy; end
    end
    m_px  = x;
    m_py  = y;
    m_pen = 1'b1;
  endtask

  // Returns one cycle after the pulse is sampled, i.e. with the FSM in SETUP.
  task automatic stroke_begin(int x, int y, int c, int sw, bit pen);
    model_stroke(x, y, c, sw, pen);
    act_q.delete();
    @(posedge clk_in); #1;
    x_in = 10'(x); y_in = 9'(y); color_in = COLOR_W'(c); sw_in = 3'(sw);
    pen_down_in = pen; nf_in = 1'b1;
    @(posedge clk_in); #1;
    nf_in = 1'b0;
    x_in = 10'($urandom); y_in = 9'($urandom);
    color_in = COLOR_W'($urandom); sw_in = 3'($urandom); pen_down_in = 1'($urandom);
    @(posedge clk_in); #1;
  endtask

  task automatic stroke_finish(string name);
    for (int k = 0; k < 40000 && busy_out; k++) begin
      @(posedge clk_in); #1;
      bus.wr_ready_in = ($urandom_range(99) < ready_pct);
    end
    bus.wr_ready_in = 1'b1;
    check({name, "_idle"}, busy_out, 0);
    check({name, "_count"}, act_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < act_q.size(); k++)
      check($sformatf("%s_pix%0d", name, k), act_q[k], exp_q[k]);
  endtask

  task automatic stroke(string name, int x, int y, int c, int sw, bit pen);
    stroke_begin(x, y, c, sw, pen);
    stroke_finish(name);
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    nf_in  = 1'b0;
    m_pen  = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    x_in = '0; y_in = '0; color_in = '0; sw_in = '0; pen_down_in = 1'b0; nf_in = 1'b0;
    bus.wr_ready_in = 1'b1;

    tbl[0]  = '{x: 10,  y: 20,  c: 5, sw: 0, pen: 1, n: 1, fx: 10,  fy: 20,  lx: 10,  ly: 20};
    tbl[1]  = '{x: 13,  y: 20,  c: 5, sw: 0, pen: 1, n: 4, fx: 10,  fy: 20,  lx: 13,  ly: 20};
    tbl[2]  = '{x: 0,   y: 0,   c: 0, sw: 0, pen: 0, n: 0, fx: 0,   fy: 0,   lx: 0,   ly: 0};
    tbl[3]  = '{x: 0,   y: 0,   c: 3, sw: 0, pen: 1, n: 1, fx: 0,   fy: 0,   lx: 0,   ly: 0};
    tbl[4]  = '{x: 3,   y: 3,   c: 3, sw: 0, pen: 1, n: 4, fx: 0,   fy: 0,   lx: 3,   ly: 3};
    tbl[5]  = '{x: 0,   y: 0,   c: 0, sw: 0, pen: 0, n: 0, fx: 0,   fy: 0,   lx: 0,   ly: 0};
    tbl[6]  = '{x: 5,   y: 0,   c: 1, sw: 0, pen: 1, n: 1, fx: 5,   fy: 0,   lx: 5,   ly: 0};
    tbl[7]  = '{x: 0,   y: 2,   c: 1, sw: 0, pen: 1, n: 6, fx: 5,   fy: 0,   lx: 0,   ly: 2};
    tbl[8]  = '{x: 0,   y: 0,   c: 0, sw: 0, pen: 0, n: 0, fx: 0,   fy: 0,   lx: 0,   ly: 0};
    tbl[9]  = '{x: 0,   y: 0,   c: 7, sw: 2, pen: 1, n: 4, fx: 0,   fy: 0,   lx: 1,   ly: 1};
    tbl[10] = '{x: 0,   y: 0,   c: 0, sw: 0, pen: 0, n: 0, fx: 0,   fy: 0,   lx: 0,   ly: 0};
    tbl[11] = '{x: 319, y: 179, c: 2, sw: 2, pen: 1, n: 4, fx: 318, fy: 178, lx: 319, ly: 179};
    tbl[12] = '{x: 0,   y: 0,   c: 0, sw: 0, pen: 0, n: 0, fx: 0,   fy: 0,   lx: 0,   ly: 0};

    // Outputs while held in reset.
    #12;
    check("rst_valid", bus.wr_valid_out, 0);
    check("rst_busy",  busy_out, 0);
    check("rst_x",     bus.wr_x_out, 0);
    check("rst_y",     bus.wr_y_out, 0);
    check("rst_color", bus.wr_color_out, 0);
    do_reset();

    // First-write latency for a single point.
    stroke_begin(10, 20, 5, 0, 1);
    check("lat_n1_valid", bus.wr_valid_out, 0);
    check("lat_n1_busy",  busy_out, 1);
    @(posedge clk_in); #1;
    check("lat_n2_valid", bus.wr_valid_out, 1);
    check("lat_n2_pix", {bus.wr_x_out, bus.wr_y_out, bus.wr_color_out}, {10'd10, 9'd20, 4'd5});
    stroke_finish("lat");

    do_reset();
    for (int t = 0; t < 13; t++) begin
      string nm;
      nm = $sformatf("vec%0d", t);
      stroke(nm, tbl[t].x, tbl[t].y, tbl[t].c, tbl[t].sw, tbl[t].pen);
      check({nm, "_n"}, act_q.size(), tbl[t].n);
      if (tbl[t].n > 0) begin
        check({nm, "_first"}, {act_q[0].x, act_q[0].y}, {10'(tbl[t].fx), 9'(tbl[t].fy)});
        check({nm, "_last"}, {act_q[act_q.size()-1].x, act_q[act_q.size()-1].y},
              {10'(tbl[t].lx), 9'(tbl[t].ly)});
      end
    end

    // Backpressure: hold ready low for five cycles mid-stroke.
    stroke("bp_a", 20, 30, 9, 1, 1);
    stroke_begin(40, 35, 9, 1, 1);
    for (int k = 0; k < 200 && act_q.size() < 3; k++) begin @(posedge clk_in); #1; end
    bus.wr_ready_in = 1'b0;
    for (int k = 0; k < 20 && !bus.wr_valid_out; k++) begin @(posedge clk_in); #1; end
    check("bp_valid_seen", bus.wr_valid_out, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_in); #1;
      check($sformatf("bp_hold_valid%0d", k), bus.wr_valid_out, 1);
      check($sformatf("bp_hold_pix%0d", k), {bus.wr_x_out, bus.wr_y_out, bus.wr_color_out},
            exp_q[act_q.size()]);
    end
    bus.wr_ready_in = 1'b1;
    stroke_finish("bp_b");

    // A frame pulse during a long segment is ignored and leaves prev_* alone.
    stroke("ign_up", 0, 0, 0, 0, 0);
    stroke("ign_dot", 0, 0, 2, 0, 1);
    stroke_begin(300, 0, 2, 0, 1);
    repeat (20) @(posedge clk_in);
    #1;
    x_in = 10'd5; y_in = 9'd150; pen_down_in = 1'b1; nf_in = 1'b1;
    @(posedge clk_in); #1;
    nf_in = 1'b0;
    check("ign_busy", busy_out, 1);
    stroke_finish("ign_long");
    stroke("ign_next", 0, 100, 4, 0, 1);

    // Asynchronous reset mid-segment.
    stroke_begin(10, 10, 6, 3, 1);
    repeat (10) @(posedge clk_in);
    #3;
    rst_in = 1'b0;
    #1;
    check("arst_valid", bus.wr_valid_out, 0);
    check("arst_busy",  busy_out, 0);
    check("arst_x",     bus.wr_x_out, 0);
    m_pen = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    stroke("arst_next", 50, 50, 3, 0, 1);
    check("arst_single", act_q.size(), 1);

    // Randomized strokes with random backpressure.
    ready_pct = 70;
    for (int t = 0; t < 30; t++) begin
      int x, y, c, sw;
      bit pen;
      pen = ($urandom_range(3) != 0);
      if (m_pen) begin
        x = m_px + int'($urandom_range(80)) - 40;
        y = m_py + int'($urandom_range(80)) - 40;
      end else begin
        x = int'($urandom_range(H_MAX + 10));
        y = int'($urandom_range(V_MAX + 10));
      end
      x  = (x < 0) ? 0 : (x > H_MAX + 10) ? H_MAX + 10 : x;
      y  = (y < 0) ? 0 : (y > V_MAX + 10) ? V_MAX + 10 : y;
      c  = int'($urandom_range(15));
      sw = int'($urandom_range(7));
      stroke($sformatf("rnd%0d", t), x, y, c, sw, pen);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
